// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, polarity normalisation and a
// counter-qualified debounce FSM with registered press/release/long-press strobes.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter int INVERT          = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic          IDLE_PIN  = 1'(INVERT);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t          state, state_nxt;
    logic            sync_p0, sync_p1;
    logic            s;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [HW-1:0]   hold, hold_nxt;
    logic            level_nxt, press_nxt, release_nxt, long_nxt;

    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        return (v == HOLD_MAX) ? v : v + 1'b1;
    endfunction

    // Synchroniser stage: flops hold the raw pin, so they reset to its idle value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= IDLE_PIN;
            sync_p1 <= IDLE_PIN;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    assign s = sync_p1 ^ IDLE_PIN;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hold_nxt    = hold;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        case (state)
            RELEASED: begin
                if (s) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                hold_nxt = sat_inc(hold);
                if (hold == HOLD_LAST) long_nxt = 1'b1;
                if (!s) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                // A bounce back high resumes PRESSED with the hold count intact.
                if (s) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = RELEASED;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = RELEASED;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

    // FSM stage: state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RELEASED;
            cnt           <= '0;
            hold          <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hold          <= hold_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_press    <= long_nxt;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: table of pin segments with expected strobe times
// queued on drive and matched by a strobe monitor; reset sequence hand-written.
module tb_button_debouncer;

    localparam int KP = 1;
    localparam int KR = 2;
    localparam int KL = 3;

    logic clk;
    logic reset_n;
    logic pin0, pin1;
    logic lvl0, prs0, rel0, lng0;
    logic lvl1, prs1, rel1, lng1;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int id;
        bit pin;
        int clks;
        bit lvl;
        int k1;
        int o1;
        int k2;
        int o2;
    } row_t;

    typedef struct {
        int id;
        int kind;
        int cyc;
    } ev_t;

    ev_t  exp_q[$];
    row_t rows[18];

    button_debouncer #(.DEBOUNCE_CYCLES(8), .LONG_CYCLES(32), .INVERT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .btn_in(pin0),
        .btn_level(lvl0), .press_pulse(prs0), .release_pulse(rel0), .long_press(lng0)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(8), .LONG_CYCLES(32), .INVERT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .btn_in(pin1),
        .btn_level(lvl1), .press_pulse(prs1), .release_pulse(rel1), .long_press(lng1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_ev(input int id, input int kind, input int at);
        ev_t e;
        e.id = id;
        e.kind = kind;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic note(input int id, input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe: unexpected dut%0d kind=%0d at cycle %0d", id, kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.id != id || e.kind != kind || e.cyc != cyc) begin
                errors++;
                $display("FAIL strobe: got dut%0d kind=%0d cyc=%0d want dut%0d kind=%0d cyc=%0d",
                         id, kind, cyc, e.id, e.kind, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (prs0) note(0, KP);
        if (rel0) note(0, KR);
        if (lng0) note(0, KL);
        if (prs1) note(1, KP);
        if (rel1) note(1, KR);
        if (lng1) note(1, KL);
    end

    task automatic run_row(input row_t r);
        int start;
        if (r.id == 0) pin0 = r.pin;
        else           pin1 = r.pin;
        start = cyc;
        if (r.k1 != 0) push_ev(r.id, r.k1, start + r.o1);
        if (r.k2 != 0) push_ev(r.id, r.k2, start + r.o2);
        repeat (r.clks) @(posedge clk);
        #1;
        chk($sformatf("level dut%0d row end", r.id), (r.id == 0) ? int'(lvl0) : int'(lvl1), int'(r.lvl));
    endtask

    initial begin
        int start;
        rows[0]  = '{0, 1'b1, 20, 1'b1, KP, 11, 0, 0};
        rows[1]  = '{0, 1'b0, 20, 1'b0, KR, 11, 0, 0};
        rows[2]  = '{0, 1'b1,  5, 1'b0, 0, 0, 0, 0};
        rows[3]  = '{0, 1'b0,  2, 1'b0, 0, 0, 0, 0};
        rows[4]  = '{0, 1'b1, 20, 1'b1, KP, 11, 0, 0};
        rows[5]  = '{0, 1'b0, 20, 1'b0, KR, 11, 0, 0};
        rows[6]  = '{0, 1'b1,  8, 1'b0, 0, 0, 0, 0};
        rows[7]  = '{0, 1'b0, 20, 1'b0, 0, 0, 0, 0};
        rows[8]  = '{0, 1'b1,  9, 1'b0, KP, 11, 0, 0};
        rows[9]  = '{0, 1'b0, 20, 1'b0, KR, 11, 0, 0};
        rows[10] = '{0, 1'b1, 60, 1'b1, KP, 11, KL, 43};
        rows[11] = '{0, 1'b0,  8, 1'b1, 0, 0, 0, 0};
        rows[12] = '{0, 1'b1, 10, 1'b1, 0, 0, 0, 0};
        rows[13] = '{0, 1'b0,  4, 1'b1, 0, 0, 0, 0};
        rows[14] = '{0, 1'b1,  3, 1'b1, 0, 0, 0, 0};
        rows[15] = '{0, 1'b0, 20, 1'b0, KR, 11, 0, 0};
        rows[16] = '{1, 1'b0, 20, 1'b1, KP, 11, 0, 0};
        rows[17] = '{1, 1'b1, 20, 1'b0, KR, 11, 0, 0};

        reset_n = 1'b0;
        pin0 = 1'b0;
        pin1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset level0", lvl0, 0);
        chk("reset press0", prs0, 0);
        chk("reset release0", rel0, 0);
        chk("reset long0", lng0, 0);
        chk("reset level1", lvl1, 0);
        chk("reset press1", prs1, 0);
        chk("reset release1", rel1, 0);
        chk("reset long1", lng1, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) run_row(rows[i]);

        // Reset while pressed: outputs drop at once, no release strobe,
        // then a fresh debounce with the pin still held.
        pin0 = 1'b1;
        start = cyc;
        push_ev(0, KP, start + 11);
        repeat (20) @(posedge clk);
        #1;
        chk("pressed before reset", lvl0, 1);
        reset_n = 1'b0;
        #1;
        chk("async reset level0", lvl0, 0);
        chk("async reset press0", prs0, 0);
        chk("async reset release0", rel0, 0);
        chk("async reset long0", lng0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("in reset level0", lvl0, 0);
        reset_n = 1'b1;
        start = cyc;
        push_ev(0, KP, start + 11);
        repeat (10) @(posedge clk);
        #1;
        chk("no early press after reset", lvl0, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("pressed after reset", lvl0, 1);
        chk("invert dut idle after reset", lvl1, 0);
        pin0 = 1'b0;
        start = cyc;
        push_ev(0, KR, start + 11);
        repeat (20) @(posedge clk);
        #1;
        chk("released at end", lvl0, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("pending strobes", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
